// File: rtl/fixed_pkg.sv
// Shared definitions for the Q24.8 fixed-point arithmetic blocks:
// default widths, saturation limits and the divider state encoding.
package fixed_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FRACT_BITS = 8;

  localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/fixed_div_step.sv
// One restoring radix-2 division step on unsigned magnitudes.
// The partial remainder is shifted left with the next dividend bit appended.
// The divisor is then subtracted when it fits, which produces quotient bit 1.
module fixed_div_step #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvs_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;

  // The incoming remainder is always below the divisor, so the difference fits in W bits.
  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, dvs_i});
  assign rem_o   = q_o ? W'(shifted - {1'b0, dvs_i}) : shifted[W-1:0];

endmodule

// File: rtl/fixed_64_div.sv
// Sequential signed Q24.8 / Q24.8 -> Q24.8 divider. It computes one quotient bit
// per clock with a restoring algorithm on magnitudes, and uses a valid/ready
// handshake on both sides. The result saturates to Q_MAX/Q_MIN on overflow or
// divide-by-zero.
// Optional: define FIXED_DIV_ROUND_NEAREST_EN to run one extra guard iteration
// and round the magnitude half away from zero. With the macro undefined, the
// result is truncated toward zero.
module fixed_64_div
  import fixed_pkg::*;
#(
  parameter int unsigned DATA_W     = fixed_pkg::DATA_W,
  parameter int unsigned FRACT_BITS = fixed_pkg::FRACT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int unsigned N     = DATA_W + FRACT_BITS;
`ifdef FIXED_DIV_ROUND_NEAREST_EN
  // One extra quotient bit below the LSB acts as the rounding guard.
  localparam int unsigned STEPS = N + 1;
  localparam int unsigned SHIFT = FRACT_BITS + 1;
`else
  localparam int unsigned STEPS = N;
  localparam int unsigned SHIFT = FRACT_BITS;
`endif
  localparam int unsigned CNT_W = $clog2(STEPS);
  // DATA_W+1-bit magnitudes keep |-2^(DATA_W-1)| exact.
  localparam int unsigned MAG_W = DATA_W + 1;

  localparam logic [STEPS-1:0] POS_LIM = STEPS'(Q_MAX);
  localparam logic [STEPS-1:0] NEG_LIM = STEPS'(Q_MIN);

  div_state_t         state_q, state_d;
  logic               sign_q, sign_d;
  logic [STEPS-1:0]   dvd_q, dvd_d;
  logic [MAG_W-1:0]   dvs_q, dvs_d;
  logic [MAG_W-1:0]   rem_q, rem_d;
  logic [STEPS-2:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  quot_q, quot_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic [MAG_W-1:0]   dvd_ext, dvs_ext;
  logic [MAG_W-1:0]   dvd_mag, dvs_mag;
  logic [MAG_W-1:0]   step_rem;
  logic               step_q;
  logic [STEPS-1:0]   raw_mag, res_mag;
  logic [DATA_W-1:0]  sat_quot;
  logic               sat_ovf;

  // Restoring step for the current iteration; it consumes the dividend MSB.
  fixed_div_step #(.W(MAG_W)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (dvd_q[STEPS-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Operand magnitudes, sign-extended by one bit so -2^(DATA_W-1) negates exactly.
  always_comb begin
    dvd_ext = {dividend[DATA_W-1], dividend};
    dvs_ext = {divisor[DATA_W-1], divisor};
    dvd_mag = dividend[DATA_W-1] ? (~dvd_ext) + MAG_W'(1) : dvd_ext;
    dvs_mag = divisor[DATA_W-1]  ? (~dvs_ext) + MAG_W'(1) : dvs_ext;
  end

  // Final magnitude (with optional rounding), then sign application and saturation.
  always_comb begin
    raw_mag = {quo_q, step_q};
`ifdef FIXED_DIV_ROUND_NEAREST_EN
    res_mag = {1'b0, raw_mag[STEPS-1:1]} + STEPS'(raw_mag[0]);
`else
    res_mag = raw_mag;
`endif
    sat_ovf = 1'b0;
    if (!sign_q && (res_mag > POS_LIM)) begin
      sat_quot = Q_MAX;
      sat_ovf  = 1'b1;
    end else if (sign_q && (res_mag > NEG_LIM)) begin
      sat_quot = Q_MIN;
      sat_ovf  = 1'b1;
    end else if (sign_q) begin
      // A zero magnitude negates to zero, so -0 cannot appear.
      sat_quot = (~res_mag[DATA_W-1:0]) + DATA_W'(1);
    end else begin
      sat_quot = res_mag[DATA_W-1:0];
    end
  end

  // Next-state logic: operand capture, iteration control and the result handshake.
  always_comb begin
    // NOTE: every variable gets a default first, so no branch can infer a latch.
    state_d = state_q;
    sign_d  = sign_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = dividend[DATA_W-1] ^ divisor[DATA_W-1];
          dvd_d  = STEPS'({dvd_mag, {SHIFT{1'b0}}});
          dvs_d  = dvs_mag;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = CNT_W'(STEPS - 1);
          ovf_d  = 1'b0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            quot_d  = dividend[DATA_W-1] ? Q_MIN : Q_MAX;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[STEPS-2:0], 1'b0};
        quo_d = {quo_q[STEPS-3:0], step_q};
        if (cnt_q == '0) begin
          quot_d  = sat_quot;
          ovf_d   = sat_ovf;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
